// File: rtl/prog_clk_divider_if.sv
// prog_clk_divider_if: enable, load handshake and divided-clock outputs of the divider
interface prog_clk_divider_if #(
    parameter int CNT_W  = 26,
    parameter int NUM_CH = 2
);
    logic [NUM_CH-1:0] en;
    logic              load;
    logic [2:0]        ch_sel;
    logic [CNT_W-1:0]  term_value;
    logic              load_ack;
    logic              load_err;
    logic [NUM_CH-1:0] divided_clk;
    logic [NUM_CH-1:0] tick;
    modport master (
        output en, load, ch_sel, term_value,
        input  load_ack, load_err, divided_clk, tick
    );
    modport slave (
        input  en, load, ch_sel, term_value,
        output load_ack, load_err, divided_clk, tick
    );
endinterface

// File: rtl/prog_clk_divider.sv
// prog_clk_divider: multi-channel programmable 50% clock divider; tick strobes need PROG_CLK_DIVIDER_TICK_EN
module prog_clk_divider #(
    parameter int               CNT_W        = 26,
    parameter int               NUM_CH       = 2,
    parameter logic [CNT_W-1:0] DEFAULT_TERM = CNT_W'(40000000)
) (
    input logic               clk_in,
    input logic               rst,
    prog_clk_divider_if.slave bus
);
    localparam logic [3:0] NCH = 4'(NUM_CH);
    logic load_ok;
    assign load_ok = bus.load && ({1'b0, bus.ch_sel} < NCH);
    // load handshake: acknowledge valid channels, flag out-of-range ones
    always_ff @(posedge clk_in or posedge rst)
        if (rst) begin
            bus.load_ack <= 1'b0;
            bus.load_err <= 1'b0;
        end else begin
            bus.load_ack <= load_ok;
            bus.load_err <= bus.load && !load_ok;
        end
    genvar i;
    for (i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt, term, shd;
        logic             pending, div_q, wrap, hit;
        assign wrap = bus.en[i] && (cnt == term);
        assign hit  = load_ok && (bus.ch_sel == 3'(i));
        assign bus.divided_clk[i] = div_q;
        // counter, toggle and terminal update; a new terminal only takes effect at a wrap
        always_ff @(posedge clk_in or posedge rst)
            if (rst) begin
                cnt     <= '0;
                term    <= DEFAULT_TERM;
                shd     <= DEFAULT_TERM;
                pending <= 1'b0;
                div_q   <= 1'b0;
            end else begin
                if (bus.en[i]) cnt <= wrap ? '0 : cnt + 1'b1;
                if (wrap) div_q <= ~div_q;
                if (wrap) term <= hit ? bus.term_value : (pending ? shd : term);
                if (hit && !wrap) begin
                    shd     <= bus.term_value;
                    pending <= 1'b1;
                end else if (wrap) begin
                    pending <= 1'b0;
                end
            end
`ifdef PROG_CLK_DIVIDER_TICK_EN
        logic tick_q;
        assign bus.tick[i] = tick_q;
        // one-cycle strobe following each toggle
        always_ff @(posedge clk_in or posedge rst)
            if (rst) tick_q <= 1'b0;
            else     tick_q <= wrap;
`else
        assign bus.tick[i] = 1'b0;
`endif
    end
endmodule

// File: tb/tb_prog_clk_divider.sv
// tb_prog_clk_divider: table-driven and sequence checks of prog_clk_divider (DEFAULT_TERM=3)
module tb_prog_clk_divider;
    localparam int CW = 8;
`ifdef PROG_CLK_DIVIDER_TICK_EN
    localparam bit TICK = 1'b1;
`else
    localparam bit TICK = 1'b0;
`endif
    logic clk_in = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    prog_clk_divider_if #(.CNT_W(CW), .NUM_CH(2)) bus ();
    prog_clk_divider #(.CNT_W(CW), .NUM_CH(2), .DEFAULT_TERM(8'd3)) dut (
        .clk_in(clk_in),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk_in = ~clk_in;
    typedef struct {
        logic [1:0]    en;
        logic          load;
        logic [2:0]    ch;
        logic [CW-1:0] tv;
        logic [1:0]    div;
        logic [1:0]    tk;
        logic          ack;
        logic          err;
    } vec_t;
    vec_t vecs[13];
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic step(input logic [1:0] en, input logic ld, input logic [2:0] ch, input logic [CW-1:0] tv);
        bus.en = en;
        bus.load = ld;
        bus.ch_sel = ch;
        bus.term_value = tv;
        @(posedge clk_in);
        #1;
        bus.load = 1'b0;
    endtask
    task automatic chk_out(input string name, input logic [1:0] div, input logic [1:0] tk, input logic ack, input logic err);
        check({name, ".div"}, 32'(bus.divided_clk), 32'(div));
        check({name, ".tick"}, 32'(bus.tick), TICK ? 32'(tk) : 32'd0);
        check({name, ".ack"}, 32'(bus.load_ack), 32'(ack));
        check({name, ".err"}, 32'(bus.load_err), 32'(err));
    endtask
    initial begin
        vecs[0]  = '{2'b11, 1'b0, 3'd0, 8'd0, 2'b00, 2'b00, 1'b0, 1'b0};
        vecs[1]  = '{2'b11, 1'b0, 3'd0, 8'd0, 2'b00, 2'b00, 1'b0, 1'b0};
        vecs[2]  = '{2'b11, 1'b0, 3'd0, 8'd0, 2'b00, 2'b00, 1'b0, 1'b0};
        vecs[3]  = '{2'b11, 1'b0, 3'd0, 8'd0, 2'b11, 2'b11, 1'b0, 1'b0};
        vecs[4]  = '{2'b11, 1'b0, 3'd0, 8'd0, 2'b11, 2'b00, 1'b0, 1'b0};
        vecs[5]  = '{2'b11, 1'b1, 3'd1, 8'd0, 2'b11, 2'b00, 1'b1, 1'b0};
        vecs[6]  = '{2'b11, 1'b0, 3'd0, 8'd0, 2'b11, 2'b00, 1'b0, 1'b0};
        vecs[7]  = '{2'b11, 1'b0, 3'd0, 8'd0, 2'b00, 2'b11, 1'b0, 1'b0};
        vecs[8]  = '{2'b11, 1'b0, 3'd0, 8'd0, 2'b10, 2'b10, 1'b0, 1'b0};
        vecs[9]  = '{2'b11, 1'b1, 3'd7, 8'd5, 2'b00, 2'b10, 1'b0, 1'b1};
        vecs[10] = '{2'b11, 1'b0, 3'd0, 8'd0, 2'b10, 2'b10, 1'b0, 1'b0};
        vecs[11] = '{2'b11, 1'b0, 3'd0, 8'd0, 2'b01, 2'b11, 1'b0, 1'b0};
        vecs[12] = '{2'b11, 1'b0, 3'd0, 8'd0, 2'b11, 2'b10, 1'b0, 1'b0};
        bus.en = 2'b00;
        bus.load = 1'b0;
        bus.ch_sel = 3'd0;
        bus.term_value = '0;
        repeat (2) @(posedge clk_in);
        #1;
        chk_out("reset", 2'b00, 2'b00, 1'b0, 1'b0);
        @(negedge clk_in);
        rst = 1'b0;
        for (int k = 0; k < 13; k++) begin
            step(vecs[k].en, vecs[k].load, vecs[k].ch, vecs[k].tv);
            chk_out($sformatf("vec%0d", k + 1), vecs[k].div, vecs[k].tk, vecs[k].ack, vecs[k].err);
        end
        #2 rst = 1'b1;
        #1 chk_out("async_rst", 2'b00, 2'b00, 1'b0, 1'b0);
        @(negedge clk_in);
        rst = 1'b0;
        step(2'b01, 1'b0, 3'd0, 8'd0);
        step(2'b01, 1'b0, 3'd0, 8'd0);
        for (int k = 0; k < 5; k++) begin
            step(2'b00, 1'b0, 3'd0, 8'd0);
            chk_out($sformatf("hold%0d", k), 2'b00, 2'b00, 1'b0, 1'b0);
        end
        step(2'b01, 1'b0, 3'd0, 8'd0);
        chk_out("resume_cnt3", 2'b00, 2'b00, 1'b0, 1'b0);
        step(2'b01, 1'b0, 3'd0, 8'd0);
        chk_out("delayed_wrap", 2'b01, 2'b01, 1'b0, 1'b0);
        repeat (3) step(2'b01, 1'b0, 3'd0, 8'd0);
        step(2'b01, 1'b1, 3'd0, 8'd1);
        chk_out("bypass_wrap", 2'b00, 2'b01, 1'b1, 1'b0);
        step(2'b01, 1'b0, 3'd0, 8'd0);
        chk_out("bypass_h1", 2'b00, 2'b00, 1'b0, 1'b0);
        step(2'b01, 1'b0, 3'd0, 8'd0);
        chk_out("bypass_r", 2'b01, 2'b01, 1'b0, 1'b0);
        step(2'b01, 1'b0, 3'd0, 8'd0);
        chk_out("bypass_h2", 2'b01, 2'b00, 1'b0, 1'b0);
        step(2'b01, 1'b0, 3'd0, 8'd0);
        chk_out("bypass_f", 2'b00, 2'b01, 1'b0, 1'b0);
        step(2'b01, 1'b1, 3'd0, 8'd7);
        chk_out("pend_load", 2'b00, 2'b00, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1 chk_out("rst_pend", 2'b00, 2'b00, 1'b0, 1'b0);
        @(posedge clk_in);
        @(negedge clk_in);
        rst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step(2'b01, 1'b0, 3'd0, 8'd0);
            chk_out($sformatf("post_rst%0d", k), (k == 4) ? 2'b01 : 2'b00, (k == 4) ? 2'b01 : 2'b00, 1'b0, 1'b0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/prog_clk_divider.md
PROG_CLK_DIVIDER -- requirements
Module: prog_clk_divider

Interface
REQ-001 Parameter CNT_W, default 26, counter and terminal-value width in bits.
REQ-002 Parameter NUM_CH, default 2, number of independent divider channels (1..8).
REQ-003 Parameter DEFAULT_TERM, default 40000000, terminal count loaded into every channel at reset.
REQ-004 Port clk_in  input  1  clock; all state SHALL update on its rising edge.
REQ-005 Port rst  input  1  reset, asynchronous, active-high.
REQ-006 Port en  input  NUM_CH  per-channel count enable.
REQ-007 Port load  input  1  single-cycle request to program a new terminal value.
REQ-008 Port ch_sel  input  3  channel targeted by load.
REQ-009 Port term_value  input  CNT_W  terminal value sampled with load.
REQ-010 Port load_ack  output  1  one-cycle pulse: load accepted.
REQ-011 Port load_err  output  1  one-cycle pulse: load rejected (ch_sel >= NUM_CH).
REQ-012 Port divided_clk  output  NUM_CH  registered 50%-duty divided clocks.
REQ-013 Port tick  output  NUM_CH  registered one-cycle strobes at each toggle.

Function
REQ-014 Each channel SHALL hold a CNT_W-bit counter cnt, an active terminal term, a shadow terminal shd and a pending flag.
REQ-015 When en[i]=1 and cnt==term: cnt<=0, divided_clk[i] inverts, tick[i]=1 for the next cycle ("wrap").
REQ-016 When en[i]=1 and cnt!=term: cnt<=cnt+1, divided_clk[i] holds, tick[i]=0.
REQ-017 When en[i]=0: cnt and divided_clk[i] hold, tick[i]=0; re-asserting en resumes from the held count.
REQ-018 Output period SHALL be 2*(term+1) clk_in cycles; term=0 gives divide-by-2.
REQ-019 load=1 with ch_sel<NUM_CH: shd<=term_value, pending<=1, load_ack=1 on the following cycle.
REQ-020 load=1 with ch_sel>=NUM_CH: no state change; load_err=1 on the following cycle.
REQ-021 A pending shadow SHALL be copied to term only at that channel's wrap, clearing pending; no mid-period change of term.
REQ-022 Load and wrap on the same channel in the same cycle: the new term_value SHALL become term at that wrap (bypass), pending stays 0.
REQ-023 Multiple loads to one channel before its wrap: last value wins.
REQ-024 If pending and cnt>shd, the channel SHALL still count to the old term before switching (no overshoot wrap-around past 2^CNT_W).
REQ-025 Channels SHALL be fully independent; a load to one channel SHALL not disturb any other.

Reset
REQ-026 While rst=1: cnt=0, term=DEFAULT_TERM, shd=DEFAULT_TERM, pending=0, divided_clk=0, tick=0, load_ack=0, load_err=0.
REQ-027 Reset asserted mid-period or with a load pending SHALL discard the pending value.
REQ-028 First wrap after rst release with en=1 SHALL occur DEFAULT_TERM+1 cycles later.

Configuration
REQ-029 Macro PROG_CLK_DIVIDER_TICK_EN defined: tick outputs behave per REQ-015..017.
REQ-030 Macro PROG_CLK_DIVIDER_TICK_EN undefined: tick ports remain, driven constant 0, no tick registers synthesised; all other behaviour identical.

Verification
REQ-031 DEFAULT_TERM=3, en=1 after reset -> divided_clk[0] rises at cycle 4, falls at 8; tick pulses at 4, 8, 12.
REQ-032 load ch_sel=1 term_value=0 mid-period -> load_ack next cycle; channel 1 keeps old period until wrap, then toggles every cycle; channel 0 unchanged.
REQ-033 load ch_sel=7 with NUM_CH=2 -> load_err one cycle, no channel state change, no load_ack.
REQ-034 en[0] low for 5 cycles at cnt=2 -> cnt and divided_clk held, tick 0; wrap delayed exactly 5 cycles.
REQ-035 load coincident with wrap (term 3 -> 1) -> next half-period 2 cycles; rst asserted with pending load -> term returns to DEFAULT_TERM, outputs 0.
REQ-036 Build without PROG_CLK_DIVIDER_TICK_EN, rerun REQ-031 -> identical divided_clk, tick constant 0.
